led_blink_selector: RTL

Parametrised successor to the fixed four-rate LED blinker. It drives an LED from a single shared half-period counter whose reload value comes from a NUM_FREQ-entry table, selected by a SEL_W-bit switch bus. Switch and enable inputs are asynchronous and are synchronised; the switch bus is also debounced. Rate changes are glitch-free, and the output is registered. It sits between the board switches/enable and the LED pad.

---
 rtl/led_blink_selector.sv | 122 ++++++++++++
 1 files changed

// File: rtl/led_blink_selector.sv
// led_blink_selector: LED blinker whose half-period is picked from a parameter table by a debounced switch bus.
// Latency: a switch edge is applied DEBOUNCE_CYCLES+3 clocks later; o_led_drive lags the internal toggle by 1 clock.
// Backpressure: none; free-running, inputs are sampled every clock and outputs are always valid.
module led_blink_selector #(
    parameter int NUM_FREQ = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 32,
    parameter logic [NUM_FREQ*CNT_W-1:0] HALF_PERIODS = {32'd12500, 32'd1250, 32'd250, 32'd125},
    parameter int DEBOUNCE_CYCLES = 250
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [SEL_W-1:0] i_switch,
    output logic             o_led_drive,
    output logic [SEL_W-1:0] o_active_sel,
    output logic             o_sel_changed
);
    localparam int NUM_SEL = 2**SEL_W;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SEL_W-1:0] sw_m;
    logic [SEL_W-1:0] sw_s;
    logic             en_m;
    logic             en_s;
    logic [SEL_W-1:0] candidate;
    logic [DB_W-1:0]  db_cnt;
    logic [SEL_W-1:0] active_sel;
    logic [CNT_W-1:0] counter;
    logic             toggle;

    // Table expanded to every switch code; codes at or above NUM_FREQ reuse the top entry,
    // which is exactly the clamp, so both lookups stay in range for any SEL_W.
    logic [CNT_W-1:0] half_tbl  [NUM_SEL];
    logic [SEL_W-1:0] clamp_tbl [NUM_SEL];

    genvar g;
    generate
        for (g = 0; g < NUM_SEL; g++) begin : g_tbl
            localparam int K = (g < NUM_FREQ) ? g : NUM_FREQ - 1;
            assign half_tbl[g]  = HALF_PERIODS[CNT_W*K +: CNT_W];
            assign clamp_tbl[g] = SEL_W'(K);
        end
    endgenerate

    logic [SEL_W-1:0] cand_clamped;
    logic [CNT_W-1:0] half_cur;
    logic             accept;

    // Accept fires once the candidate has been stable long enough and differs (after clamp) from the applied rate
    always_comb begin
        cand_clamped = clamp_tbl[candidate];
        half_cur     = half_tbl[active_sel];
        accept       = (sw_s == candidate) && (db_cnt == DB_LAST) && (cand_clamped != active_sel);
    end

    // Two-flop synchronisers for the asynchronous switch bus and enable
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sw_m <= '0;
            sw_s <= '0;
            en_m <= 1'b0;
            en_s <= 1'b0;
        end else begin
            sw_m <= i_switch;
            sw_s <= sw_m;
            en_m <= i_enable;
            en_s <= en_m;
        end
    end

    // Debounce: any change restarts the count; the count saturates at DB_LAST while waiting
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            candidate     <= '0;
            db_cnt        <= '0;
            active_sel    <= '0;
            o_sel_changed <= 1'b0;
        end else begin
            o_sel_changed <= 1'b0;
            if (sw_s != candidate) begin
                candidate <= sw_s;
                db_cnt    <= '0;
            end else if (db_cnt == DB_LAST) begin
                if (accept) begin
                    active_sel    <= cand_clamped;
                    o_sel_changed <= 1'b1;
                end
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Shared half-period counter; a rate change restarts the count but keeps the toggle level (no runt pulse)
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            counter <= '0;
            toggle  <= 1'b0;
        end else if (accept) begin
            counter <= '0;
        end else if (counter == half_cur - CNT_W'(1)) begin
            counter <= '0;
            toggle  <= ~toggle;
        end else begin
            counter <= counter + CNT_W'(1);
        end
    end

    // Registered LED drive; the toggle keeps running while disabled so phase is retained
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_led_drive <= 1'b0;
        end else begin
            o_led_drive <= toggle & en_s;
        end
    end

    assign o_active_sel = active_sel;

endmodule
